// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares exmem port 2 between a priority display reader and two round-robin requesters
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [2:0]              req,
    input  logic [2:0]              we,
    input  logic [3*ADDR_WIDTH-1:0] addr_bus,
    input  logic [3*DATA_WIDTH-1:0] wdata_bus,
    output logic [2:0]              gnt,
    output logic [2:0]              rvalid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_din,
    output logic                    mem_we,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, READ} state_t;

    state_t                r_state, w_state_nx;
    logic [2:0]            r_gnt, w_gnt_nx;
    logic [2:0]            r_rvalid, w_rvalid_nx;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nx;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nx;
    logic [DATA_WIDTH-1:0] r_mem_din, w_mem_din_nx;
    logic                  r_mem_we, w_mem_we_nx;
    logic [1:0]            r_rr_last, w_rr_last_nx;
    logic [1:0]            r_w, w_w_nx;
    logic [1:0]            w_win;

    // Winner: requester 0 always first; otherwise the one of 1/2 that did not win last time
    always_comb begin
        w_win = req[0] ? 2'd0 :
                (req[1] & req[2]) ? ((r_rr_last == 2'd1) ? 2'd2 : 2'd1) :
                req[1] ? 2'd1 : 2'd2;
    end

    // Next-state and registered-output values for the IDLE -> ISSUE -> (READ) sequence
    always_comb begin
        w_state_nx    = r_state;
        w_gnt_nx      = 3'b000;
        w_rvalid_nx   = 3'b000;
        w_rdata_nx    = r_rdata;
        w_mem_addr_nx = r_mem_addr;
        w_mem_din_nx  = r_mem_din;
        w_mem_we_nx   = 1'b0;
        w_rr_last_nx  = r_rr_last;
        w_w_nx        = r_w;
        if (r_state == IDLE && req != 3'b000) begin
            w_state_nx    = ISSUE;
            w_gnt_nx      = 3'b001 << w_win;
            w_mem_addr_nx = addr_bus[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
            w_mem_din_nx  = wdata_bus[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
            w_mem_we_nx   = we[w_win];
            w_w_nx        = w_win;
            w_rr_last_nx  = (w_win == 2'd0) ? r_rr_last : w_win;
        end else if (r_state == ISSUE) begin
            w_state_nx = r_mem_we ? IDLE : READ;
        end else if (r_state == READ) begin
            w_state_nx  = IDLE;
            w_rdata_nx  = mem_rdata;
            w_rvalid_nx = 3'b001 << r_w;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_gnt      <= 3'b000;
            r_rvalid   <= 3'b000;
            r_rdata    <= '0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_we   <= 1'b0;
            r_rr_last  <= 2'd2;
            r_w        <= 2'd0;
        end else begin
            r_state    <= w_state_nx;
            r_gnt      <= w_gnt_nx;
            r_rvalid   <= w_rvalid_nx;
            r_rdata    <= w_rdata_nx;
            r_mem_addr <= w_mem_addr_nx;
            r_mem_din  <= w_mem_din_nx;
            r_mem_we   <= w_mem_we_nx;
            r_rr_last  <= w_rr_last_nx;
            r_w        <= w_w_nx;
        end
    end

    assign gnt      = r_gnt;
    assign rvalid   = r_rvalid;
    assign rdata    = r_rdata;
    assign busy     = (r_state != IDLE);
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    // The write strobe is qualified by reset_n so a reset landing on the issue edge cancels the write
    assign mem_we   = r_mem_we & reset_n;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed checks against a transaction-level reference model
module tb_mem_port_arbiter;
    localparam int DW = 16;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    req = 3'b000;
    logic [2:0]    we = 3'b000;
    logic [AW-1:0] ad [3];
    logic [DW-1:0] wd [3];
    logic [3*AW-1:0] addr_bus;
    logic [3*DW-1:0] wdata_bus;
    logic [2:0]    gnt, rvalid;
    logic [DW-1:0] rdata, mem_din, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          busy, mem_we;

    logic [DW-1:0] mem     [0:65535];
    logic [DW-1:0] ref_mem [0:65535];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    bit            m_act;
    int            m_age, m_w, rr;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, cap;
    logic [2:0]    e_gnt, e_rv;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_rd;

    assign addr_bus  = {ad[2], ad[1], ad[0]};
    assign wdata_bus = {wd[2], wd[1], wd[0]};

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we),
        .addr_bus(addr_bus), .wdata_bus(wdata_bus),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // exmem port 2: synchronous write, registered read
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_rdata <= mem[mem_addr];
    end

    function automatic logic [DW-1:0] init_val(int i);
        return 16'(i * 257) ^ 16'hA5A5;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock: advance the reference model by one edge, then compare every output
    task automatic tick();
        bit idle;
        int w;
        @(posedge clk);
        cyc++;
        idle  = !m_act;
        e_gnt = 3'b000;
        e_rv  = 3'b000;
        e_we  = 1'b0;
        if (!reset_n) begin
            m_act  = 0;
            rr     = 2;
            e_rd   = '0;
            e_addr = '0;
            e_din  = '0;
        end else begin
            if (m_act) begin
                m_age++;
                if (m_age == 1 && m_we) begin
                    ref_mem[m_addr] = m_data;
                    m_act = 0;
                end else if (m_age == 1) begin
                    cap = ref_mem[m_addr];
                end else if (m_age == 2) begin
                    e_rv  = 3'(1 << m_w);
                    e_rd  = cap;
                    m_act = 0;
                end
            end
            if (idle && req != 3'b000) begin
                if (req[0]) w = 0;
                else if (req[1] && req[2]) w = 3 - rr;
                else if (req[1]) w = 1;
                else w = 2;
                if (w != 0) rr = w;
                e_gnt  = 3'(1 << w);
                e_we   = we[w];
                e_addr = ad[w];
                e_din  = wd[w];
                m_act  = 1;
                m_age  = 0;
                m_w    = w;
                m_we   = we[w];
                m_addr = ad[w];
                m_data = wd[w];
            end
        end
        #1;
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("rvalid", 32'(rvalid), 32'(e_rv));
        check("rdata", 32'(rdata), 32'(e_rd));
        check("busy", 32'(busy), 32'(m_act));
        check("mem_addr", 32'(mem_addr), 32'(e_addr));
        check("mem_din", 32'(mem_din), 32'(e_din));
        check("mem_we", 32'(mem_we & reset_n), 32'(e_we));
    endtask

    // Tick n times; requesters drop req once granted
    task automatic run(int n);
        for (int k = 0; k < n; k++) begin
            tick();
            for (int i = 0; i < 3; i++) if (e_gnt[i]) req[i] = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = init_val(i);
            ref_mem[i] = init_val(i);
        end
        mem[16'h0010]     = 16'hBEEF;
        ref_mem[16'h0010] = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            ad[i] = '0;
            wd[i] = '0;
        end
        m_act = 0;
        rr    = 2;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;

        req = 3'b010; we = 3'b000; ad[1] = 16'h0010;
        run(5);

        req = 3'b100; we = 3'b100; ad[2] = 16'h0020; wd[2] = 16'h1234;
        run(3);
        req = 3'b100; we = 3'b000;
        run(4);

        req = 3'b110; we = 3'b000; ad[1] = 16'h0001; ad[2] = 16'h0002;
        for (int k = 0; k < 12; k++) tick();
        req = 3'b000;
        run(3);

        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        req = 3'b111; we = 3'b000; ad[0] = 16'h0003;
        for (int k = 0; k < 9; k++) tick();
        req[0] = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        req = 3'b000;
        run(4);

        req = 3'b010; we = 3'b000; ad[1] = 16'h0010;
        tick();
        req = 3'b000;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        req = 3'b010;
        run(5);

        req = 3'b100; we = 3'b100; ad[2] = 16'h0030; wd[2] = 16'hDEAD;
        tick();
        req = 3'b000;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("t6_nowrite", 32'(mem[16'h0030]), 32'(init_val(16'h0030)));
        run(3);

        for (int k = 0; k < 1500; k++) begin
            tick();
            reset_n = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < 3; i++) begin
                if (!req[i] || e_gnt[i]) begin
                    req[i] = ($urandom_range(0, 99) < ((i == 0) ? 25 : 55));
                    we[i]  = 1'($urandom_range(0, 1));
                    ad[i]  = 16'($urandom_range(0, 63));
                    wd[i]  = 16'($urandom);
                end
            end
        end
        reset_n = 1'b1;
        req = 3'b000;
        run(4);
        for (int a = 0; a < 64; a++) check("mem_final", 32'(mem[a]), 32'(ref_mem[a]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
